uart_rx_frame: RTL
==================

# uart_rx_frame

UART receive framer for the serial debug/host link. It synchronizes the asynchronous `rs232_rx` line and detects the start-bit edge. It drives `bps_start` to the team's baud-rate generator and samples the line on each returned mid-bit strobe `clk_bps`. It then delivers each received character through a one-entry valid/ready output register, with framing, parity and overrun status.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per character (5–8), sent LSB first.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `rs232_rx` in 1: asynchronous serial line. Idles high.
- `bps_start` out 1: baud-generator run request. High from start-edge detection until the stop-bit sample.
- `clk_bps` in 1: one-cycle mid-bit strobe from the baud generator. The first strobe arrives half a bit after `bps_start` rises.
- `rx_data` out DATA_BITS: received character. Bits above DATA_BITS are not used.
- `rx_valid` out 1: `rx_data`, `rx_ferr` and `rx_perr` are valid.
- `rx_ready` in 1: consumer accepts the character.
- `rx_ferr` out 1: framing error (stop bit sampled 0). Qualified by `rx_valid`.
- `rx_perr` out 1: parity mismatch. Qualified by `rx_valid`. Always 0 when PARITY=0.
- `rx_overrun` out 1: one-cycle pulse when a character is dropped.

## Operation
- Input synchronizer:
  - Two flops, then one edge register. All three reset to 1.
  - A falling edge is detected when the edge register holds 1 and the second synchronizer flop holds 0.
- State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `bps_start`=0.
  - On a falling edge, go to START and set `bps_start`=1.
  - Edges are only honoured in IDLE.
- START, on `clk_bps`:
  - Synchronized line = 1: false start (glitch). Go to IDLE and clear `bps_start`.
  - Otherwise: go to DATA, with the bit counter at 0.
- DATA, on each `clk_bps`:
  - Shift the sample into the shift register MSB side, so the first bit received ends up as LSB.
  - After DATA_BITS samples, go to PARITY if PARITY≠0, else STOP.
- PARITY, on `clk_bps`:
  - Sample the parity bit.
  - perr = XOR of the data bits and the parity bit, compared with the expected result. Odd parity expects a total of 1; even parity expects 0.
- STOP, on `clk_bps`:
  - Sample the stop bit; ferr = the inverted sample.
  - Complete the character, go to IDLE, and clear `bps_start` in the same cycle.
- Completion, with the output register empty or being accepted in that same cycle:
  - Load `rx_data`, `rx_ferr` and `rx_perr`.
  - Set `rx_valid`.
- Completion while `rx_valid`=1 and `rx_ready`=0:
  - The new character is dropped and the held character is kept.
  - `rx_overrun` pulses for one cycle.
- Handshake:
  - A transfer occurs on any cycle with `rx_valid` && `rx_ready`.
  - `rx_valid` clears on the next cycle unless a new completion coincides.
- A character with a framing error is still delivered, flagged with `rx_ferr`.
- Break (line held low): no new frame starts until the line returns high and falls again, because edge detection requires a prior high.

## Timing
- `rs232_rx` falling edge to `bps_start`=1: 3 clock edges (2 sync + edge register).
- `clk_bps` in STOP to `rx_valid`=1: 1 cycle. The outputs are registered.
- `clk_bps` in START to `bps_start`=0 on a false start: 1 cycle.
- `bps_start` stays continuously high for the whole frame. Deasserting it resets the generator counter.
- `clk_bps` outside START/DATA/PARITY/STOP is ignored.
- Reset values:
  - `bps_start`, `rx_valid`, `rx_ferr`, `rx_perr`, `rx_overrun` = 0.
  - `rx_data` = 0.
  - State = IDLE.
  - Synchronizer = all 1.
- Reset asserted mid-frame: the next cycle has the reset values. The partial character is discarded and no `rx_overrun` is raised.

## Structure
- Package `uart_pkg` holds:
  - The state enum.
  - The parity-mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2).
  - The default DATA_BITS.
- Sub-module `uart_rx_sync`: two-flop synchronizer plus falling-edge detector. It outputs `rx_sync` and `rx_fall`.
- The rest (FSM, shift register, bit counter, output register) stays in `uart_rx_frame`.

## Test plan
All scenarios use a behavioural baud generator: 1302-cycle bit, strobe 651 cycles after `bps_start` rises and then every 1302 cycles.
- **Basic 8N1**: `rx_ready`=1, send 0x55 → one `rx_valid` cycle with `rx_data`=0x55, `rx_ferr`=0, `rx_perr`=0. `bps_start` falls on the stop strobe.
- **False start**: line low for 300 cycles, then high → `bps_start` rises, then falls 1 cycle after the first strobe. No `rx_valid`.
- **Framing error**: send 0xA3 with the stop bit driven 0 → `rx_data`=0xA3, `rx_ferr`=1. No new frame until the line goes high and falls again.
- **Overrun**: `rx_ready`=0, send 0x12 then 0x34:
  - `rx_data` holds 0x12.
  - `rx_overrun` pulses once at the 0x34 stop strobe.
  - After raising `rx_ready`, 0x12 is accepted and `rx_valid` clears.
- **Even parity** (PARITY=2): send 0x07 with parity bit 1 → `rx_perr`=0. Send 0x07 with parity bit 0 → `rx_perr`=1.
- **Reset mid-frame**: assert `rst` for 1 cycle after the 4th data strobe → next cycle `bps_start`=0 and all outputs 0. A following clean 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEFAULT_DATA_BITS = 8;

  // ones_xor is the XOR of every data bit and the received parity bit.
  function automatic logic parity_error(input logic ones_xor, input int mode);
    case (mode)
      PAR_ODD:  return ~ones_xor;
      PAR_EVEN: return ones_xor;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge detector.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rs232_rx,
  output logic rx_sync,
  output logic rx_fall
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  // Everything resets to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so each stage takes the pre-edge value of the one before it.
      sync1_q <= rs232_rx;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign rx_sync = sync2_q;
  assign rx_fall = edge_q & ~sync2_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detection, baud-run request, bit sampling on the
// generator strobe, and a one-entry valid/ready output register with status.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int PARITY    = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  output logic                 bps_start,
  input  logic                 clk_bps,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_ferr,
  output logic                 rx_perr,
  output logic                 rx_overrun
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_e state_q, state_d;
  logic                 rx_sync;
  logic                 rx_fall;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 complete;
  logic                 frame_perr;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rs232_rx (rs232_rx),
    .rx_sync  (rx_sync),
    .rx_fall  (rx_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bps_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      bps_start <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path through the case assigns everything and no latch appears.
    state_d  = state_q;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (rx_fall) state_d = ST_START;
      ST_START:  if (clk_bps) state_d = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:   if (clk_bps && bit_cnt_q == LAST_BIT)
                   state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (clk_bps) state_d = ST_STOP;
      ST_STOP: begin
        if (clk_bps) begin
          state_d  = ST_IDLE;
          complete = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // First bit received lands in the LSB after DATA_BITS right shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else if (clk_bps) begin
      if (state_q == ST_START) bit_cnt_q <= '0;
      if (state_q == ST_DATA) begin
        shift_q   <= {rx_sync, shift_q[DATA_BITS-1:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (state_q == ST_PARITY) par_q <= rx_sync;
    end
  end

  assign frame_perr = parity_error(^shift_q ^ par_q, PARITY);

  // A completion while the held character is still unaccepted drops the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_perr    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (complete && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_ferr  <= ~rx_sync;
        rx_perr  <= frame_perr;
        rx_valid <= 1'b1;
      end else begin
        if (complete) rx_overrun <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

endmodule
